// File: rtl/cpu_output_uart_tx_if.sv
// Bundle of CPU output-stream inputs and UART/status outputs for cpu_output_uart_tx.
// The master side drives the CPU stream. The slave side is the UART sink.
interface cpu_output_uart_tx_if;
    logic        output_valid;
    logic [63:0] output_data;
    logic        halt;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic        done;

    modport master (
        output output_valid, output_data, halt,
        input  tx, busy, overflow, done
    );

    modport slave (
        input  output_valid, output_data, halt,
        output tx, busy, overflow, done
    );
endinterface

// File: rtl/cpu_output_uart_tx.sv
// Captures 64-bit CPU output words into a FIFO and prints each one as "0x%016x\n" on an 8N1 UART.
// Tracks halt and raises a sticky done once every accepted word has been fully sent.
module cpu_output_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_output_uart_tx_if.slave   bus
);
    localparam int                PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [4:0]        LAST_CHAR = 5'd18;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic [63:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    state_e            state_q, state_d;
    logic [63:0]       shift_q, shift_d;
    logic [4:0]        char_q, char_d;
    logic [2:0]        bit_q, bit_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic              tx_q, tx_d;
    logic              halt_seen_q, overflow_q, done_q;
    logic              push, pop, fifo_empty, fifo_full, baud_wrap;
    logic [7:0]        cur_char;
    logic [3:0]        nib;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);
    assign push       = bus.output_valid && !fifo_full && !halt_seen_q;
    assign baud_wrap  = (baud_q == BAUD_LAST);

    assign bus.tx       = tx_q;
    assign bus.busy     = !fifo_empty || (state_q != IDLE);
    assign bus.overflow = overflow_q;
    assign bus.done     = done_q;

    // Character 0 is '0', 1 is 'x', 2..17 are the hex nibbles MSB first, and 18 is LF.
    always_comb begin
        nib      = shift_q[63:60];
        cur_char = 8'h0A;
        if (char_q == 5'd0)            cur_char = 8'h30;
        else if (char_q == 5'd1)       cur_char = 8'h78;
        else if (char_q < LAST_CHAR)   cur_char = (nib < 4'd10) ? {4'h3, nib} : 8'h57 + {4'h0, nib};
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        char_d  = char_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    char_d  = '0;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_wrap) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                tx_d = cur_char[bit_q];
                if (baud_wrap) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (char_q < LAST_CHAR) begin
                        if (char_q >= 5'd2) shift_d = {shift_q[59:0], 4'h0};
                        char_d  = char_q + 5'd1;
                        state_d = START;
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        char_d  = '0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: FIFO storage has no reset; the cleared pointers and count make old contents unreachable.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.output_data;
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            shift_q     <= '0;
            char_q      <= '0;
            bit_q       <= '0;
            baud_q      <= '0;
            tx_q        <= 1'b1;
            halt_seen_q <= 1'b0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            state_q <= state_d;
            shift_q <= shift_d;
            char_q  <= char_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            tx_q    <= tx_d;
            if (bus.halt) halt_seen_q <= 1'b1;
            if (bus.output_valid && fifo_full && !halt_seen_q) overflow_q <= 1'b1;
            if (halt_seen_q && fifo_empty && state_q == IDLE) done_q <= 1'b1;
        end
    end
endmodule

// File: doc/cpu_output_uart_tx.md
# cpu_output_uart_tx

Sink for the CPU output stream. Captures every 64-bit word the CPU presents on `output_valid`/`output_data` into a small FIFO. Transmits each word as ASCII text `0x` + 16 lowercase hex digits + LF on an 8N1 UART line. Tracks `halt` and signals `done` once all captured output has been sent, so a board top or bench can stop cleanly.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; must be ≥ 2.
- `FIFO_DEPTH`, default 8: word FIFO entries; power of two, ≥ 2.

- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `output_valid`  in  1  CPU output word present this cycle; no backpressure.
- `output_data`  in  64  CPU output word.
- `halt`  in  1  CPU halted; may be a level or a pulse.
- `tx`  out  1  UART serial line, idle high.
- `busy`  out  1  high when the FIFO is non-empty or the transmitter is not IDLE.
- `overflow`  out  1  sticky; a word was dropped.
- `done`  out  1  sticky; halt seen and all accepted words fully transmitted.

## Operation
- **Capture**
  - A word is pushed on a rising edge where `output_valid`=1, the FIFO is not full (count before the edge), and `halt_seen`=0.
  - A word presented on the same edge where `halt` is first sampled high is accepted.
  - `halt_seen` is an internal sticky bit set on any edge where `halt`=1.
  - If `output_valid`=1 and the FIFO is full, the word is dropped and `overflow` sets. A pop on that same edge does not rescue the word.
  - Push and pop on the same edge are both honoured; count is unchanged.
- **Transmitter FSM: IDLE, START, DATA, STOP**
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into a 64-bit shift register, set char index to 0, and go to START.
  - Character stream per word (19 chars): `0`(0x30), `x`(0x78), then nibbles [63:60] down to [3:0] mapped to `0`–`9` / `a`–`f`, then LF(0x0A).
  - START: `tx`=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles.
  - After STOP:
    - If index < 18: increment the index and go to START directly, with no idle gap.
    - If index = 18 and the FIFO is non-empty: pop the next word, index=0, go to START with no gap.
    - Otherwise go to IDLE.
  - Bit counter is 3 bits. Baud counter is `$clog2(CLKS_PER_BIT)` bits and wraps to 0 at CLKS_PER_BIT−1.
- **Done**
  - `done` registers to 1 on the first edge where `halt_seen`=1, the FIFO is empty, and the state is IDLE.
  - It stays at 1 until reset.
  - `output_valid` is ignored after `halt_seen`.

## Timing
- **Reset values:** `tx`=1, `busy`=0, `overflow`=0, `done`=0. The FIFO, pointers, FSM state (IDLE), counters, and `halt_seen` are all cleared.
- **Reset mid-frame:** `tx` returns high asynchronously and the frame is abandoned, with no partial continuation after release.
- **Latency with the transmitter idle and the FIFO empty:**
  - Word sampled at edge N; FIFO non-empty after N.
  - Popped at edge N+1; `tx` falls after edge N+2.
  - `busy` rises after edge N.
- **Frame length:** 190×CLKS_PER_BIT cycles per word, which is 3040 cycles at the default. Back-to-back words have zero idle cycles between the LF stop bit and the next start bit.
- **Sustained throughput** is one word per 190×CLKS_PER_BIT cycles. Bursts beyond FIFO_DEPTH+1 words (FIFO plus the shift register) overflow.
- **`done` timing:**
  - After the final stop bit, FSM enters IDLE at edge M and `done`=1 after edge M+1.
  - If `halt` arrives with the FIFO empty and the FSM in IDLE at edge H, then `halt_seen` is set after H and `done`=1 after H+1.

## Test plan
- **Single word** (CLKS_PER_BIT=4): `output_valid`=1 for one cycle with 0x0123456789abcdef.
  - UART decode yields `0x0123456789abcdef\n`.
  - `tx` first low 2 edges after capture; frame lasts 760 cycles.
  - `busy` is 0 afterwards.
- **Zero and all-ones:** 0x0000000000000000 then 0xffffffffffffffff on consecutive cycles.
  - Output is `0x0000000000000000\n0xffffffffffffffff\n` with no idle bit time between frames.
- **Overflow** (FIFO_DEPTH=2): four consecutive valid cycles carrying words 1, 2, 3, 4.
  - Words 1–3 are transmitted in order; word 4 is dropped.
  - `overflow`=1 from the edge after word 4 until reset.
- **Halt drain:** two words, then `halt` pulse one cycle later, then `output_valid` with 0xdead.
  - Only the two words are sent; 0xdead is ignored.
  - `done` rises exactly one edge after the FSM returns to IDLE.
- **Halt with empty FIFO:** `halt`=1 at edge H with nothing captured.
  - `done`=1 after H+1; `tx` stays 1.
- **Reset mid-frame:** assert `reset` during the DATA state of char 5.
  - `tx`=1 immediately and all outputs take their reset values.
  - A new word after release transmits a complete, correct frame.
